tree_channel_merger: RTL and testbench

- Receive-side counterpart of the nearest-point channel selector. The selector chooses which of CHANNEL_COUNT channels a message leaves on; this block takes the other end of those channels.
- Merges CHANNEL_COUNT incoming valid/ready message channels into one local stream using round-robin arbitration.
- Buffers messages in a 2-entry FIFO and tags each one with the index of the channel it arrived on.
- Flags whether the message's 2D target address equals this node's address, so the downstream logic can consume it or re-forward it.

---
 rtl/tree_channel_merger_pkg.sv | 30 +++
 rtl/tree_channel_merger_if.sv | 32 +++
 rtl/tree_channel_merger_rr_arbiter.sv | 42 ++++
 rtl/tree_channel_merger.sv | 92 +++++++++
 tb/tb_tree_channel_merger.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tree_channel_merger_pkg.sv
// rtl/tree_channel_merger_pkg.sv - shared width helpers and message field extraction for the channel selector/merger pair.
package tree_channel_merger_pkg;

  localparam int DEFAULT_PER_DIMENSION_WIDTH = 4;
  localparam int DEFAULT_CHANNEL_COUNT       = 5;
  localparam int DEFAULT_PAYLOAD_WIDTH       = 8;

  function automatic int address_width(input int per_dimension_width);
    return 2 * per_dimension_width;
  endfunction

  function automatic int channel_width(input int channel_count);
    return (channel_count > 1) ? $clog2(channel_count) : 1;
  endfunction

  function automatic int msg_width(input int per_dimension_width, input int payload_width);
    return address_width(per_dimension_width) + payload_width;
  endfunction

  // Messages are {target, payload}; callers zero-extend into 64 bits so one helper serves every width.
  function automatic logic [31:0] target_of(input logic [63:0] msg, input int addr_width,
                                            input int payload_width);
    return 32'((msg >> payload_width) & ((64'd1 << addr_width) - 64'd1));
  endfunction

  function automatic logic [31:0] payload_of(input logic [63:0] msg, input int payload_width);
    return 32'(msg & ((64'd1 << payload_width) - 64'd1));
  endfunction

endpackage

// File: rtl/tree_channel_merger_if.sv
// rtl/tree_channel_merger_if.sv - incoming channel bundle plus outgoing local stream of the merger.
interface tree_channel_merger_if
  import tree_channel_merger_pkg::*;
#(
  parameter int PER_DIMENSION_WIDTH = DEFAULT_PER_DIMENSION_WIDTH,
  parameter int CHANNEL_COUNT       = DEFAULT_CHANNEL_COUNT,
  parameter int PAYLOAD_WIDTH       = DEFAULT_PAYLOAD_WIDTH
);
  localparam int ADDRESS_WIDTH = address_width(PER_DIMENSION_WIDTH);
  localparam int CHANNEL_WIDTH = channel_width(CHANNEL_COUNT);
  localparam int MSG_WIDTH     = msg_width(PER_DIMENSION_WIDTH, PAYLOAD_WIDTH);

  logic [ADDRESS_WIDTH-1:0]           local_address;
  logic [CHANNEL_COUNT*MSG_WIDTH-1:0] in_data;
  logic [CHANNEL_COUNT-1:0]           in_valid;
  logic [CHANNEL_COUNT-1:0]           in_ready;
  logic [MSG_WIDTH-1:0]               out_data;
  logic [CHANNEL_WIDTH-1:0]           out_src_idx;
  logic                               out_is_local;
  logic                               out_valid;
  logic                               out_ready;

  modport slave (
    input  local_address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src_idx, out_is_local, out_valid
  );

  modport master (
    output local_address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src_idx, out_is_local, out_valid
  );
endinterface

// File: rtl/tree_channel_merger_rr_arbiter.sv
// rtl/tree_channel_merger_rr_arbiter.sv - round-robin arbiter; the pointer wraps explicitly so N need not be a power of 2.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);
  logic [W-1:0] ptr;
  logic [W-1:0] scan_idx;
  int           scan_pos;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_pos    = 0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_pos = int'(ptr) + k;
      if (scan_pos >= N) scan_pos = scan_pos - N;
      scan_idx = W'(scan_pos);
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/tree_channel_merger.sv
// rtl/tree_channel_merger.sv - merges incoming channels round-robin into a 2-entry tagged FIFO with a local-address flag.
module tree_channel_merger
  import tree_channel_merger_pkg::*;
#(
  parameter int PER_DIMENSION_WIDTH = DEFAULT_PER_DIMENSION_WIDTH,
  parameter int CHANNEL_COUNT       = DEFAULT_CHANNEL_COUNT,
  parameter int PAYLOAD_WIDTH       = DEFAULT_PAYLOAD_WIDTH
) (
  input logic                  clk,
  input logic                  reset,
  tree_channel_merger_if.slave bus
);
  localparam int ADDRESS_WIDTH = address_width(PER_DIMENSION_WIDTH);
  localparam int CHANNEL_WIDTH = channel_width(CHANNEL_COUNT);
  localparam int MSG_WIDTH     = msg_width(PER_DIMENSION_WIDTH, PAYLOAD_WIDTH);

  typedef struct packed {
    logic [MSG_WIDTH-1:0]     data;
    logic [CHANNEL_WIDTH-1:0] src;
    logic                     is_local;
  } entry_t;

  logic [CHANNEL_COUNT-1:0] grant;
  logic [CHANNEL_WIDTH-1:0] grant_idx;
  logic                     grant_valid;
  logic [1:0]               count;
  entry_t                   head, tail, incoming;
  logic [MSG_WIDTH-1:0]     granted_msg;
  logic                     space, push, pop;

  assign space = (count < 2'd2) || ((count == 2'd2) && bus.out_ready);
  assign push  = space && grant_valid && !reset;
  assign pop   = (count != 2'd0) && bus.out_ready;
  assign bus.in_ready = push ? grant : '0;

  rr_arbiter #(.N(CHANNEL_COUNT), .W(CHANNEL_WIDTH)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.in_valid),
    .advance    (push),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // One-hot grant makes the OR-reduction a clean mux without a variable part-select.
  always_comb begin
    granted_msg = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (grant[i]) granted_msg = granted_msg | bus.in_data[i*MSG_WIDTH +: MSG_WIDTH];
    end
    incoming.data     = granted_msg;
    incoming.src      = grant_idx;
    incoming.is_local = target_of(64'(granted_msg), ADDRESS_WIDTH, PAYLOAD_WIDTH)
                        == 32'(bus.local_address);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= incoming;
          else               tail <= incoming;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // With one entry the popped head is replaced directly; with two the tail advances.
        2'b11: begin
          if (count == 2'd1) begin
            head <= incoming;
          end else begin
            head <= tail;
            tail <= incoming;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid    = (count != 2'd0);
  assign bus.out_data     = head.data;
  assign bus.out_src_idx  = head.src;
  assign bus.out_is_local = head.is_local;
endmodule

// File: tb/tb_tree_channel_merger.sv
// tb/tb_tree_channel_merger.sv - vector table, corner sequences and random model check for tree_channel_merger.
module tb_tree_channel_merger;
  localparam int NCH = 5;
  localparam int MW  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tree_channel_merger_if bus ();
  tree_channel_merger dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [NCH-1:0] ch_valid;
  logic [MW-1:0]  ch_data [NCH];

  typedef struct {
    logic [7:0]  local_addr;
    int          ch;
    logic [15:0] msg;
    logic [4:0]  exp_ready;
    logic        exp_local;
  } vec_t;
  vec_t vecs[6];

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  src;
    logic        loc;
  } ent_t;
  ent_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) bus.in_data[i*MW +: MW] = ch_data[i];
    bus.in_valid = ch_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ch_valid = '0;
    bus.out_ready = 1'b0;
    drive();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int m_ptr, g;
    logic found, space, push, pop;
    logic [4:0] exp_ready;

    reset = 1'b1;
    bus.local_address = 8'h00;
    bus.out_ready = 1'b0;
    ch_valid = '0;
    for (int i = 0; i < NCH; i++) ch_data[i] = '0;
    drive();
    step();
    step();
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_rr_ptr", 32'(dut.u_arb.ptr), 32'd0);
      step();
    end

    vecs[0] = '{8'h64, 3, 16'h64A5, 5'b01000, 1'b1};
    vecs[1] = '{8'h00, 1, 16'hF03C, 5'b00010, 1'b0};
    vecs[2] = '{8'h00, 0, 16'h0011, 5'b00001, 1'b1};
    vecs[3] = '{8'hFF, 4, 16'hFFEE, 5'b10000, 1'b1};
    vecs[4] = '{8'h37, 2, 16'h7300, 5'b00100, 1'b0};
    vecs[5] = '{8'h9A, 4, 16'h9B00, 5'b10000, 1'b0};
    for (int v = 0; v < 6; v++) begin
      bus.local_address = vecs[v].local_addr;
      ch_valid = '0;
      ch_valid[vecs[v].ch] = 1'b1;
      ch_data[vecs[v].ch] = vecs[v].msg;
      bus.out_ready = 1'b1;
      drive();
      @(negedge clk);
      check("vec_in_ready", 32'(bus.in_ready), 32'(vecs[v].exp_ready));
      check("vec_no_comb_path", 32'(bus.out_valid), 32'd0);
      step();
      ch_valid = '0;
      drive();
      @(negedge clk);
      check("vec_out_valid", 32'(bus.out_valid), 32'd1);
      check("vec_out_data", 32'(bus.out_data), 32'(vecs[v].msg));
      check("vec_out_src", 32'(bus.out_src_idx), 32'(vecs[v].ch));
      check("vec_out_local", 32'(bus.out_is_local), 32'(vecs[v].exp_local));
      step();
    end

    // Round-robin fairness at full rate
    do_reset();
    for (int i = 0; i < NCH; i++) ch_data[i] = 16'h1000 * i[15:0] + 16'h0055;
    ch_valid = '1;
    bus.out_ready = 1'b1;
    drive();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rr_in_ready", 32'(bus.in_ready), 32'(1) << (k % 5));
      if (k > 0) begin
        check("rr_out_valid", 32'(bus.out_valid), 32'd1);
        check("rr_out_src", 32'(bus.out_src_idx), 32'((k - 1) % 5));
      end
      step();
    end

    // Wrap and skip: pointer at 4 after a grant to 3
    do_reset();
    ch_valid = 5'b01000;
    bus.out_ready = 1'b1;
    drive();
    step();
    ch_valid = '0;
    drive();
    step();
    check("wrap_ptr_after_3", 32'(dut.u_arb.ptr), 32'd4);
    ch_valid = 5'b10010;
    drive();
    @(negedge clk); check("wrap_grant_a", 32'(bus.in_ready), 32'b10000); step();
    @(negedge clk); check("wrap_grant_b", 32'(bus.in_ready), 32'b00010); step();
    @(negedge clk); check("wrap_grant_c", 32'(bus.in_ready), 32'b10000); step();

    // Backpressure, then single-cycle drain, then asynchronous reset while holding entries
    do_reset();
    ch_data[0] = 16'hA000;
    ch_data[2] = 16'hC002;
    ch_valid = 5'b00101;
    drive();
    @(negedge clk); check("bp_accept_0", 32'(bus.in_ready), 32'b00001); step();
    @(negedge clk); check("bp_accept_2", 32'(bus.in_ready), 32'b00100); step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_src", 32'(bus.out_src_idx), 32'd0);
      check("bp_hold_data", 32'(bus.out_data), 32'hA000);
      step();
    end
    bus.out_ready = 1'b1;
    drive();
    @(negedge clk); check("bp_pop_push_ready", 32'(bus.in_ready), 32'b00001); step();
    bus.out_ready = 1'b0;
    drive();
    @(negedge clk);
    check("bp_new_head_src", 32'(bus.out_src_idx), 32'd2);
    check("bp_new_head_data", 32'(bus.out_data), 32'hC002);
    check("bp_full_again", 32'(bus.in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_ready", 32'(bus.in_ready), 32'd0);
    check("async_reset_ptr", 32'(dut.u_arb.ptr), 32'd0);
    step();
    reset = 1'b0;

    // Randomized traffic against a queue model
    bus.local_address = 8'($urandom);
    do_reset();
    model_q.delete();
    m_ptr = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_valid[i] && $urandom_range(0, 2) == 0) begin
          ch_valid[i] = 1'b1;
          ch_data[i] = ($urandom_range(0, 1) == 1) ? {bus.local_address, 8'($urandom)}
                                                   : 16'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive();
      @(negedge clk);
      found = 1'b0;
      g = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && ch_valid[(m_ptr + k) % NCH]) begin
          found = 1'b1;
          g = (m_ptr + k) % NCH;
        end
      end
      space = (model_q.size() < 2) || (model_q.size() == 2 && bus.out_ready);
      push = space && found;
      pop = (model_q.size() > 0) && bus.out_ready;
      exp_ready = push ? (5'b00001 << g) : 5'b00000;
      check("rand_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("rand_out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("rand_out_data", 32'(bus.out_data), 32'(model_q[0].data));
        check("rand_out_src", 32'(bus.out_src_idx), 32'(model_q[0].src));
        check("rand_out_local", 32'(bus.out_is_local), 32'(model_q[0].loc));
      end
      step();
      if (pop) void'(model_q.pop_front());
      if (push) begin
        model_q.push_back('{ch_data[g], 3'(g), ch_data[g][15:8] == bus.local_address});
        m_ptr = (g + 1) % NCH;
        ch_valid[g] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
